// File: rtl/prod_disp_pkg.sv
// Shared definitions for the multiplier display path: FSM encoding, BCD digit
// width and the digit-count helper used to size the converter.
package prod_disp_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    // Smallest digit count d such that 10**d exceeds the largest w-bit value.
    function automatic int digits_for_width(input int w);
        longint max_val;
        longint pow10;
        int     d;
        max_val = (longint'(1) << w) - 1;
        pow10   = 10;
        d       = 1;
        for (int i = 0; i < 19; i++) begin
            if (pow10 <= max_val) begin
                pow10 = pow10 * 10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/prod_bin2bcd_seq_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module bcd_digit_adj
    import prod_disp_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_DIGIT_W'(5)) begin
            dout = din + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/prod_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding
// the seven-segment scanner with a packed BCD result and leading-zero blanks.
module prod_bin2bcd_seq
    import prod_disp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = digits_for_width(WIDTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]           blank,
    output logic                        done,
    output logic                        busy
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    conv_state_t      state;
    conv_state_t      state_nxt;
    logic [WIDTH-1:0] bin_sr;
    logic [SCR_W-1:0] scr;
    logic [SCR_W-1:0] scr_adj;
    logic [SCR_W-1:0] scr_shift;
    logic             scr_unused_msb;
    logic [CNT_W-1:0] cnt;
    logic [DIGITS-1:0] blank_nxt;
    logic             accept;
    logic             last_iter;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scr[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .dout (scr_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    // The adjusted scratch never reaches its top bit for a correctly sized
    // DIGITS, so the bit shifted out of the scratch register is always zero.
    assign {scr_unused_msb, scr_shift} = {scr_adj, bin_sr[WIDTH-1]};

    assign blank_nxt[0] = 1'b0;
    for (genvar i = 1; i < DIGITS; i++) begin : g_blank
        assign blank_nxt[i] = ~|scr_shift[SCR_W-1:BCD_DIGIT_W*i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    last_iter = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs only move on the final iteration, so the display never sees a
    // partially converted value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_sr <= '0;
            scr    <= '0;
            cnt    <= '0;
            bcd    <= '0;
            blank  <= BLANK_RST;
            done   <= 1'b0;
        end else begin
            done <= last_iter;
            if (accept) begin
                bin_sr <= in_data;
                scr    <= '0;
                cnt    <= '0;
            end else if (busy) begin
                bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
                scr    <= scr_shift;
                cnt    <= cnt + CNT_W'(1);
            end
            if (last_iter) begin
                bcd   <= scr_shift;
                blank <= blank_nxt;
            end
        end
    end

endmodule
